// File: rtl/dft_sequencer.sv
// Direct-DFT (MAC mode) sequencer: drives cache fill, (n,k) issue, pipeline-aligned
// accumulator enables and the X[k] write-back handshake for a MAC_LAT-deep multiplier path.
module dft_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              n_Reset,
  input  logic              mac_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] samp_number,
  input  logic              load_done,
  output logic              cache_wr,
  output logic [ADDR_W-1:0] n_index,
  output logic [ADDR_W-1:0] k_index,
  output logic              acc_ce,
  output logic              acc_first,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  // state              | meaning
  // IDLE / LOAD_WAIT   | wait for start / for all N samples in RAM
  // CACHE_FILL/COMPUTE | copy RAM into cache / issue one (n,k) product per cycle
  // DRAIN/WRITE/DONE   | flush MAC pipe / hand X[k] to RAM / completion pulse
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_WAIT  = 3'd1,
    S_CACHE_FILL = 3'd2,
    S_COMPUTE    = 3'd3,
    S_DRAIN      = 3'd4,
    S_WRITE      = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  localparam logic [2:0] DRAIN_LOAD = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [2:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] n_last;
  logic              issue_valid;
  logic              issue_first;

  assign n_last = len_q - ADDR_W'(1);

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      n_q     <= n_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    n_d         = n_q;
    k_d         = k_q;
    drain_d     = drain_q;
    cache_wr    = 1'b0;
    issue_valid = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && mac_en) begin
          len_d   = samp_number;
          n_d     = '0;
          k_d     = '0;
          state_d = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        // An empty transform completes without touching the cache or MACs.
        if (len_q == '0) begin
          state_d = S_DONE;
        end else if (load_done) begin
          n_d     = '0;
          state_d = S_CACHE_FILL;
        end
      end
      S_CACHE_FILL: begin
        cache_wr = 1'b1;
        if (n_q == n_last) begin
          n_d     = '0;
          k_d     = '0;
          state_d = S_COMPUTE;
        end else begin
          n_d = n_q + ADDR_W'(1);
        end
      end
      S_COMPUTE: begin
        issue_valid = 1'b1;
        if (n_q == n_last) begin
          n_d     = '0;
          drain_d = DRAIN_LOAD;
          state_d = (MAC_LAT == 0) ? S_WRITE : S_DRAIN;
        end else begin
          n_d = n_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = S_WRITE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      S_WRITE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          n_d = '0;
          if (k_q == n_last) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d     = k_q + ADDR_W'(1);
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign issue_first = issue_valid && (n_q == '0);

  // Accumulator controls trail the issue by exactly the multiplier latency.
  generate
    if (MAC_LAT == 0) begin : g_no_delay
      assign acc_ce    = issue_valid;
      assign acc_first = issue_first;
    end else begin : g_delay
      logic [MAC_LAT-1:0] ce_pipe_q, ce_pipe_d;
      logic [MAC_LAT-1:0] first_pipe_q, first_pipe_d;

      always_comb begin
        ce_pipe_d    = MAC_LAT'({ce_pipe_q, issue_valid});
        first_pipe_d = MAC_LAT'({first_pipe_q, issue_first});
      end

      always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
          ce_pipe_q    <= '0;
          first_pipe_q <= '0;
        end else begin
          ce_pipe_q    <= ce_pipe_d;
          first_pipe_q <= first_pipe_d;
        end
      end

      assign acc_ce    = ce_pipe_q[MAC_LAT-1];
      assign acc_first = first_pipe_q[MAC_LAT-1];
    end
  endgenerate

  assign n_index  = n_q;
  assign k_index  = k_q;
  assign res_addr = k_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;

endmodule

// File: tb/tb_dft_sequencer.sv
// Directed bench for dft_sequencer: per-cycle traces of three instances (MAC_LAT 2, 3, 0)
// compared against a timing table built from N, MAC_LAT and any res_ready stall.
module tb_dft_sequencer;

  localparam int AW   = 12;
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          n_Reset;
  logic          mac_en;
  logic          load_done;
  logic          res_ready;
  logic [AW-1:0] samp_number;
  logic          start_v [3];

  logic          cw_w   [3];
  logic          ce_w   [3];
  logic          af_w   [3];
  logic          rv_w   [3];
  logic          busy_w [3];
  logic          done_w [3];
  logic [AW-1:0] ni_w   [3];
  logic [AW-1:0] ki_w   [3];
  logic [AW-1:0] ra_w   [3];
  logic [2:0]    st_w   [3];

  int n_checks = 0;
  int n_fail   = 0;

  int r_st [MAXC], r_cw [MAXC], r_ni [MAXC], r_ki [MAXC], r_ce [MAXC];
  int r_af [MAXC], r_rv [MAXC], r_ra [MAXC], r_bz [MAXC], r_dn [MAXC];
  int e_st [MAXC], e_cw [MAXC], e_ni [MAXC], e_ki [MAXC], e_ce [MAXC];
  int e_af [MAXC], e_rv [MAXC], e_ra [MAXC], e_bz [MAXC], e_dn [MAXC];

  always #5 clk = ~clk;

  dft_sequencer #(.ADDR_W(AW), .MAC_LAT(2)) u_dut_l2 (
    .clk(clk), .n_Reset(n_Reset), .mac_en(mac_en), .start(start_v[0]),
    .samp_number(samp_number), .load_done(load_done), .cache_wr(cw_w[0]),
    .n_index(ni_w[0]), .k_index(ki_w[0]), .acc_ce(ce_w[0]), .acc_first(af_w[0]),
    .res_valid(rv_w[0]), .res_ready(res_ready), .res_addr(ra_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .state(st_w[0])
  );

  dft_sequencer #(.ADDR_W(AW), .MAC_LAT(3)) u_dut_l3 (
    .clk(clk), .n_Reset(n_Reset), .mac_en(mac_en), .start(start_v[1]),
    .samp_number(samp_number), .load_done(load_done), .cache_wr(cw_w[1]),
    .n_index(ni_w[1]), .k_index(ki_w[1]), .acc_ce(ce_w[1]), .acc_first(af_w[1]),
    .res_valid(rv_w[1]), .res_ready(res_ready), .res_addr(ra_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .state(st_w[1])
  );

  dft_sequencer #(.ADDR_W(AW), .MAC_LAT(0)) u_dut_l0 (
    .clk(clk), .n_Reset(n_Reset), .mac_en(mac_en), .start(start_v[2]),
    .samp_number(samp_number), .load_done(load_done), .cache_wr(cw_w[2]),
    .n_index(ni_w[2]), .k_index(ki_w[2]), .acc_ce(ce_w[2]), .acc_first(af_w[2]),
    .res_valid(rv_w[2]), .res_ready(res_ready), .res_addr(ra_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .state(st_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected timeline with start in cycle 0 and load_done already high:
  // LOAD_WAIT at 1, cache fill at 2..N+1, then per bin N issue + L drain + WRITE cycles.
  task automatic build_exp(input int n, input int l, input bit acc,
                           input int stall_bin, input int stall_len);
    int b;
    int w;
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_st[i] = 0; e_cw[i] = 0; e_ni[i] = 0; e_ki[i] = 0; e_ce[i] = 0;
      e_af[i] = 0; e_rv[i] = 0; e_ra[i] = 0;
    end
    if (acc) begin
      e_st[1] = 1;
      if (n == 0) begin
        e_st[2] = 6;
      end else begin
        for (int i = 0; i < n; i++) begin
          e_st[2+i] = 2; e_cw[2+i] = 1; e_ni[2+i] = i;
        end
        b = n + 2;
        for (int k = 0; k < n; k++) begin
          for (int i = 0; i < n; i++) begin
            c = b + i;
            e_st[c] = 3; e_ni[c] = i; e_ki[c] = k;
            e_ce[c+l] = 1;
            if (i == 0) e_af[c+l] = 1;
          end
          for (int d = 0; d < l; d++) begin
            e_st[b+n+d] = 4; e_ki[b+n+d] = k;
          end
          w = (k == stall_bin) ? stall_len + 1 : 1;
          for (int j = 0; j < w; j++) begin
            c = b + n + l + j;
            e_st[c] = 5; e_ki[c] = k; e_rv[c] = 1; e_ra[c] = k;
          end
          b = b + n + l + w;
        end
        e_st[b] = 6;
      end
    end
    for (int i = 0; i < MAXC; i++) begin
      e_bz[i] = (e_st[i] != 0) ? 1 : 0;
      e_dn[i] = (e_st[i] == 6) ? 1 : 0;
    end
  endtask

  // Called at a falling edge; that edge is cycle 0 (start high until the next rising edge).
  task automatic run_trace(input int s, input int ncyc, input int nlen,
                           input int inj_lo, input int inj_hi,
                           input int stall_lo, input int stall_hi);
    for (int c = 0; c < ncyc; c++) begin
      r_st[c] = int'(st_w[s]);  r_cw[c] = int'(cw_w[s]); r_ni[c] = int'(ni_w[s]);
      r_ki[c] = int'(ki_w[s]);  r_ce[c] = int'(ce_w[s]); r_af[c] = int'(af_w[s]);
      r_rv[c] = int'(rv_w[s]);  r_ra[c] = int'(ra_w[s]); r_bz[c] = int'(busy_w[s]);
      r_dn[c] = int'(done_w[s]);
      start_v[s]  = (c == 0) || (c >= inj_lo && c < inj_hi);
      samp_number = (c >= inj_lo && c < inj_hi) ? AW'(7) : AW'(nlen);
      res_ready   = !(c >= stall_lo && c < stall_hi);
      @(negedge clk);
    end
    start_v[s] = 1'b0;
    res_ready  = 1'b1;
  endtask

  task automatic cmp_trace(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("%s c%0d state", name, c), 32'(r_st[c]), 32'(e_st[c]));
      chk($sformatf("%s c%0d cache_wr", name, c), 32'(r_cw[c]), 32'(e_cw[c]));
      chk($sformatf("%s c%0d n_index", name, c), 32'(r_ni[c]), 32'(e_ni[c]));
      chk($sformatf("%s c%0d acc_ce", name, c), 32'(r_ce[c]), 32'(e_ce[c]));
      chk($sformatf("%s c%0d acc_first", name, c), 32'(r_af[c]), 32'(e_af[c]));
      chk($sformatf("%s c%0d res_valid", name, c), 32'(r_rv[c]), 32'(e_rv[c]));
      chk($sformatf("%s c%0d busy", name, c), 32'(r_bz[c]), 32'(e_bz[c]));
      chk($sformatf("%s c%0d done", name, c), 32'(r_dn[c]), 32'(e_dn[c]));
      if (e_st[c] >= 3 && e_st[c] <= 5)
        chk($sformatf("%s c%0d k_index", name, c), 32'(r_ki[c]), 32'(e_ki[c]));
      if (e_st[c] == 5)
        chk($sformatf("%s c%0d res_addr", name, c), 32'(r_ra[c]), 32'(e_ra[c]));
    end
  endtask

  task automatic chk_idle_outputs(input string name, input int s);
    chk($sformatf("%s state", name), 32'(st_w[s]), 32'd0);
    chk($sformatf("%s busy", name), 32'(busy_w[s]), 32'd0);
    chk($sformatf("%s done", name), 32'(done_w[s]), 32'd0);
    chk($sformatf("%s cache_wr", name), 32'(cw_w[s]), 32'd0);
    chk($sformatf("%s n_index", name), 32'(ni_w[s]), 32'd0);
    chk($sformatf("%s k_index", name), 32'(ki_w[s]), 32'd0);
    chk($sformatf("%s acc_ce", name), 32'(ce_w[s]), 32'd0);
    chk($sformatf("%s acc_first", name), 32'(af_w[s]), 32'd0);
    chk($sformatf("%s res_valid", name), 32'(rv_w[s]), 32'd0);
    chk($sformatf("%s res_addr", name), 32'(ra_w[s]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_Reset     = 1'b0;
    mac_en      = 1'b1;
    load_done   = 1'b1;
    res_ready   = 1'b1;
    samp_number = '0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_outputs($sformatf("in_reset dut%0d", i), i);
    n_Reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_outputs($sformatf("post_reset dut%0d", i), i);

    // N=4, L=2: res_valid at 12/19/26/33, done at 34
    build_exp(4, 2, 1'b1, -1, 0);
    run_trace(0, 40, 4, -1, -1, -1, -1);
    cmp_trace("nominal", 40);

    // N=5, L=3: acc_ce 3 cycles behind issue, res_valid right after last acc_ce
    build_exp(5, 3, 1'b1, -1, 0);
    run_trace(1, 56, 5, -1, -1, -1, -1);
    cmp_trace("align", 56);

    // N=3, L=2: bin 1 WRITE starts at cycle 16, res_ready low 16..19
    build_exp(3, 2, 1'b1, 1, 4);
    run_trace(0, 30, 3, -1, -1, 16, 20);
    cmp_trace("backpressure", 30);

    build_exp(0, 2, 1'b1, -1, 0);
    run_trace(0, 6, 0, -1, -1, -1, -1);
    cmp_trace("n0", 6);

    build_exp(1, 2, 1'b1, -1, 0);
    run_trace(0, 10, 1, -1, -1, -1, -1);
    cmp_trace("n1", 10);

    build_exp(3, 0, 1'b1, -1, 0);
    run_trace(2, 20, 3, -1, -1, -1, -1);
    cmp_trace("lat0", 20);

    mac_en = 1'b0;
    build_exp(4, 2, 1'b0, -1, 0);
    run_trace(0, 6, 4, -1, -1, -1, -1);
    cmp_trace("mac_off", 6);
    mac_en = 1'b1;

    // start pulses and samp_number=7 during bin 0 COMPUTE (cycles 6..9) must be ignored
    build_exp(4, 2, 1'b1, -1, 0);
    run_trace(0, 40, 4, 7, 10, -1, -1);
    cmp_trace("glitch", 40);

    // N=8: COMPUTE spans cycles 10..17; reset lands in cycle 12
    samp_number = AW'(8);
    start_v[0]  = 1'b1;
    @(negedge clk);
    start_v[0]  = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_compute state", 32'(st_w[0]), 32'd3);
    n_Reset = 1'b0;
    #1;
    chk_idle_outputs("async_reset", 0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold done", 32'(done_w[0]), 32'd0);
      chk("reset_hold state", 32'(st_w[0]), 32'd0);
    end
    n_Reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_release", 0);

    build_exp(2, 2, 1'b1, -1, 0);
    run_trace(0, 18, 2, -1, -1, -1, -1);
    cmp_trace("restart", 18);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dft_sequencer.md
Name: dft_sequencer

Overview:
- Sequencer for the direct-DFT (MAC mode) datapath: RAM → cache → twiddle ROM / multipliers / rounding → accumulator → RAM result write.
- Generates the n and k indices and the cache-fill strobe.
- Pipeline-aligned accumulator enables, plus a valid/ready handshake for each finished X[k] written back to RAM.
- Replaces the separate FSM and n/k counters with one block that is latency-correct for a configurable multiplier pipeline depth.

Parameters:
- ADDR_W, 12, width of sample count and n/k indices.
- MAC_LAT, 2, cycles from index issue (n_index/k_index valid) to the corresponding product at the accumulator input. Legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- n_Reset  in  1  asynchronous active-low reset.
- mac_en  in  1  MAC mode select; when 0, start is ignored in IDLE.
- start  in  1  request a transform; sampled in IDLE only.
- samp_number  in  ADDR_W  transform length N; latched on accepted start.
- load_done  in  1  AXI bridge: all N input samples are in RAM.
- cache_wr  out  1  copy RAM[n_index] into cache this cycle.
- n_index  out  ADDR_W  sample index to RAM/cache/twiddle ROM.
- k_index  out  ADDR_W  frequency bin index to twiddle ROM.
- acc_ce  out  1  accumulator enable, aligned to product arrival.
- acc_first  out  1  with acc_ce: accumulator loads the product instead of adding (n=0 term).
- res_valid  out  1  X[k] on accumulator output is final.
- res_ready  in  1  RAM write side accepts the result.
- res_addr  out  ADDR_W  result address (= k_index).
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse, transform complete.
- state  out  3  current state encoding (debug).

Behaviour:
- Reset (async, n_Reset=0):
  - State goes to IDLE; all outputs and counters are 0; the MAC_LAT delay line is cleared.
  - Reset mid-operation abandons the transform; no done pulse.
- States: IDLE=0, LOAD_WAIT=1, CACHE_FILL=2, COMPUTE=3, DRAIN=4, WRITE=5, DONE=6.
- IDLE:
  - If start=1 and mac_en=1: latch N=samp_number and go to LOAD_WAIT. Otherwise stay.
  - If the latched N=0: go directly to DONE, with no cache or compute activity.
- LOAD_WAIT: wait for load_done=1, then go to CACHE_FILL with n=0.
- CACHE_FILL:
  - cache_wr=1 and n_index=n every cycle; n increments each cycle.
  - On n=N-1: go to COMPUTE with n=0, k=0.
- COMPUTE:
  - Issue one (n,k) per cycle and assert internal issue_valid; n increments.
  - On n=N-1: go to DRAIN, or directly to WRITE if MAC_LAT=0. n resets to 0.
- Delay line:
  - acc_ce = issue_valid delayed MAC_LAT cycles.
  - acc_first = (issue_valid & n==0) delayed MAC_LAT cycles.
  - MAC_LAT=0 means combinational (same cycle).
- DRAIN: exactly MAC_LAT cycles, with no issue. The last acc_ce of bin k occurs in the final DRAIN cycle.
- WRITE:
  - res_valid=1; res_addr=k_index held stable.
  - Transition on res_valid & res_ready:
    - if k=N-1, go to DONE;
    - else k++, n=0, and go to COMPUTE.
  - res_ready low holds the state and all outputs indefinitely.
- DONE: done=1 for one cycle, then IDLE.
- k_index is held constant through COMPUTE/DRAIN/WRITE of one bin. n_index outside CACHE_FILL/COMPUTE holds 0.
- Per-bin cost: N + MAC_LAT + 1 cycles, plus any res_ready stall.
- start, samp_number and mac_en changes while busy are ignored. load_done outside LOAD_WAIT is ignored.
- N=1:
  - CACHE_FILL takes 1 cycle.
  - The single bin's COMPUTE takes 1 cycle, with acc_first=acc_ce on that one product.
- Counters compare against the latched N-1. There is no wrap past N-1.

Test Plan:
- Reset idle: n_Reset low mid-COMPUTE (N=8) → next observed state=0, all outputs 0, no done. After release, start is accepted normally.
- Nominal: N=4, MAC_LAT=2, load_done high, res_ready=1, start at cycle 0 → expected cycle-by-cycle behaviour:
  - LOAD_WAIT at cycle 1;
  - cache_wr at cycles 2-5 with n=0..3;
  - bins of 7 cycles each;
  - res_valid at cycles 12, 19, 26, 33 with res_addr 0..3;
  - done at cycle 34.
- Alignment: MAC_LAT=3, N=5 → per bin:
  - acc_ce high for exactly 5 cycles, starting 3 cycles after the first issue;
  - acc_first only on the first of those cycles;
  - res_valid the cycle after the last acc_ce.
- Backpressure: N=3, res_ready low for 4 cycles in the bin k=1 WRITE → res_valid and res_addr=1 held 5 cycles; k=2 compute starts only after the handshake.
- Edge lengths:
  - N=0 → done 2 cycles after start, with no cache_wr/acc_ce;
  - N=1 → exactly one acc_ce with acc_first=1, one res_valid at res_addr 0;
  - MAC_LAT=0 → no DRAIN state visited.
- Gating: start with mac_en=0 → remains IDLE. Start pulses and samp_number changes during COMPUTE → no effect on sequence or latched N.
